// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default build is standard read mode.
module param_sync_fifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned AF_LEVEL = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wEN,
  input  logic              rEN,
  input  logic [DATA_W-1:0] dIn,
  output logic [DATA_W-1:0] dOut,
  output logic              bFull,
  output logic              bEmpty,
  output logic              bAlmostFull,
  output logic              bAlmostEmpty,
  output logic [ADDR_W:0]   count,
  output logic              bOverflow,
  output logic              bUnderflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic [ADDR_W-1:0] rdPtrNext;
  logic [CNT_W-1:0]  countNext;
  logic              wrAccept;
  logic              rdAccept;

  // Acceptance uses the pre-edge full/empty flags only.
  always_comb begin
    wrAccept  = wEN && !bFull;
    rdAccept  = rEN && !bEmpty;
    rdPtrNext = rdPtr;
    countNext = count;
    if (rdAccept) rdPtrNext = rdPtr + ADDR_W'(1);
    if (wrAccept && !rdAccept)      countNext = count + CNT_W'(1);
    else if (!wrAccept && rdAccept) countNext = count - CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST && wrAccept) mem[wrPtr] <= dIn;
  end

  // Pointers, count and status flags; status is derived from the next count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      count        <= '0;
      bEmpty       <= 1'b1;
      bFull        <= 1'b0;
      bAlmostEmpty <= 1'b1;
      bAlmostFull  <= (AF_LEVEL == 0);
      bOverflow    <= 1'b0;
      bUnderflow   <= 1'b0;
    end else begin
      if (wrAccept) wrPtr <= wrPtr + ADDR_W'(1);
      rdPtr        <= rdPtrNext;
      count        <= countNext;
      bEmpty       <= (countNext == '0);
      bFull        <= (countNext == CNT_W'(DEPTH));
      bAlmostFull  <= (countNext >= CNT_W'(AF_LEVEL));
      bAlmostEmpty <= (countNext <= CNT_W'(AE_LEVEL));
      if (wEN && bFull)  bOverflow  <= 1'b1;
      if (rEN && bEmpty) bUnderflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dOut <= '0;
    end else begin
`ifdef PARAM_SYNC_FIFO_FWFT_EN
      // Present the next head; bypass dIn when the head slot is being written this edge.
      if (countNext != '0)
        dOut <= (wrAccept && (wrPtr == rdPtrNext)) ? dIn : mem[rdPtrNext];
`else
      if (rdAccept) dOut <= mem[rdPtr];
`endif
    end
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo: a queue-based reference model predicts every cycle's outputs,
// a separate monitor compares them against the DUT after each rising edge.
module tb_param_sync_fifo;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned AE_LEVEL = 2;
  localparam int unsigned AF_LEVEL = 6;
  localparam int unsigned DEPTH    = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RST;
  logic              wEN;
  logic              rEN;
  logic [DATA_W-1:0] dIn;
  logic [DATA_W-1:0] dOut;
  logic              bFull, bEmpty, bAlmostFull, bAlmostEmpty, bOverflow, bUnderflow;
  logic [ADDR_W:0]   count;

  param_sync_fifo #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AE_LEVEL(AE_LEVEL), .AF_LEVEL(AF_LEVEL)
  ) dut (
    .CLK(CLK), .RST(RST), .wEN(wEN), .rEN(rEN), .dIn(dIn), .dOut(dOut),
    .bFull(bFull), .bEmpty(bEmpty), .bAlmostFull(bAlmostFull), .bAlmostEmpty(bAlmostEmpty),
    .count(count), .bOverflow(bOverflow), .bUnderflow(bUnderflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DATA_W-1:0] d;
    int                cnt;
    bit                full, empty, af, ae, ovf, unf;
  } exp_t;

  exp_t              expQ[$];
  logic [DATA_W-1:0] modelQ[$];
  logic [DATA_W-1:0] modelDout = '0;
  bit                modelOvf  = 0;
  bit                modelUnf  = 0;
  int                checks    = 0;
  int                errors    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: queue semantics, then push the predicted post-edge outputs.
  task automatic step(input bit rst, input bit w, input bit r, input logic [DATA_W-1:0] d);
    exp_t e;
    bit   wasFull, wasEmpty;
    @(negedge CLK);
    RST = rst; wEN = w; rEN = r; dIn = d;
    if (rst) begin
      modelQ.delete();
      modelOvf  = 0;
      modelUnf  = 0;
      modelDout = '0;
    end else begin
      wasFull  = (modelQ.size() == DEPTH);
      wasEmpty = (modelQ.size() == 0);
      if (w && wasFull)  modelOvf = 1;
      if (r && wasEmpty) modelUnf = 1;
      if (r && !wasEmpty) begin
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        void'(modelQ.pop_front());
`else
        modelDout = modelQ.pop_front();
`endif
      end
      if (w && !wasFull) modelQ.push_back(d);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
      if (modelQ.size() != 0) modelDout = modelQ[0];
`endif
    end
    e.d     = modelDout;
    e.cnt   = modelQ.size();
    e.full  = (e.cnt == DEPTH);
    e.empty = (e.cnt == 0);
    e.af    = (e.cnt >= AF_LEVEL);
    e.ae    = (e.cnt <= AE_LEVEL);
    e.ovf   = modelOvf;
    e.unf   = modelUnf;
    expQ.push_back(e);
  endtask

  // Monitor: pops one prediction per edge that had stimulus and compares all outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        chk("dOut",         32'(dOut),         32'(e.d));
        chk("count",        32'(count),        32'(e.cnt));
        chk("bFull",        32'(bFull),        32'(e.full));
        chk("bEmpty",       32'(bEmpty),       32'(e.empty));
        chk("bAlmostFull",  32'(bAlmostFull),  32'(e.af));
        chk("bAlmostEmpty", 32'(bAlmostEmpty), 32'(e.ae));
        chk("bOverflow",    32'(bOverflow),    32'(e.ovf));
        chk("bUnderflow",   32'(bUnderflow),   32'(e.unf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pw, pr;
    RST = 1'b1; wEN = 1'b0; rEN = 1'b0; dIn = '0;
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    // Fill with A0..A7, then overflow attempt, then drain in order.
    for (int i = 0; i < 8; i++) step(0, 1, 0, DATA_W'(8'hA0 + i));
    step(0, 1, 0, 8'hFF);
    for (int i = 0; i < 8; i++) step(0, 0, 1, '0);
    // Underflow on empty, then reset clears sticky flags.
    step(0, 0, 1, '0);
    step(0, 0, 0, '0);
    step(1, 0, 0, '0);
    // Steady simultaneous read/write at count 3, wrapping pointers.
    for (int i = 0; i < 3; i++) step(0, 1, 0, DATA_W'(8'h10 + i));
    for (int i = 0; i < 20; i++) step(0, 1, 1, DATA_W'(8'h13 + i));
    for (int i = 0; i < 3; i++) step(0, 0, 1, '0);
    // Empty with write+read, then full with write+read.
    step(0, 1, 1, 8'h5A);
    for (int i = 0; i < 7; i++) step(0, 1, 0, DATA_W'(8'h60 + i));
    step(0, 1, 1, 8'h77);
    // Reset during a stream at count 5, then a single write/read of 3C.
    step(1, 0, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, DATA_W'(8'h80 + i));
    step(0, 1, 1, 8'h85);
    step(1, 1, 1, 8'h86);
    step(0, 1, 0, 8'h3C);
    step(0, 0, 1, '0);
    step(0, 0, 0, '0);
    // Randomized traffic with shifting write/read bias and rare resets.
    for (int seg = 0; seg < 8; seg++) begin
      pw = (seg % 2 == 0) ? 75 : 30;
      pr = (seg % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 60; i++)
        step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < pw,
             $urandom_range(0, 99) < pr, DATA_W'($urandom));
    end
    @(negedge CLK);
    wEN = 1'b0; rEN = 1'b0; RST = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    chk("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
